pdcch_frame_builder: RTL and testbench

//  Upstream of the PDCCH data router. Merges one frame request, a config-word stream and a data-word stream

---
 rtl/pdcch_frame_pkg.sv | 13 +
 rtl/pdcch_frame_builder_if.sv | 37 +++
 rtl/pdcch_frame_builder_axis_out_slice.sv | 31 +++
 rtl/pdcch_frame_builder.sv | 110 +++++++++++
 tb/tb_pdcch_frame_builder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pdcch_frame_pkg.sv
// rtl/pdcch_frame_pkg.sv - shared types, header field widths and header packing for the PDCCH frame builder
package pdcch_frame_pkg;
  localparam int HDR_CFG_LEN_W = 10;
  localparam int HDR_NPKT_W    = 54;
  localparam int FRAME_W       = HDR_CFG_LEN_W + HDR_NPKT_W;

  typedef enum logic [1:0] {IDLE, HDR, CFG, DAT} state_t;

  function automatic logic [FRAME_W-1:0] hdr_pack(input logic [HDR_NPKT_W-1:0]    npkt,
                                                  input logic [HDR_CFG_LEN_W-1:0] cfg_len);
    return {npkt, cfg_len};
  endfunction
endpackage

// File: rtl/pdcch_frame_builder_if.sv
// rtl/pdcch_frame_builder_if.sv - request, config, data and frame stream bundle for the PDCCH frame builder
interface pdcch_frame_builder_if;
  import pdcch_frame_pkg::*;

  logic [HDR_CFG_LEN_W-1:0] s_axis_req_cfg_len;
  logic [HDR_NPKT_W-1:0]    s_axis_req_num_pkts;
  logic                     s_axis_req_valid;
  logic                     s_axis_req_ready;
  logic [FRAME_W-1:0]       s_axis_cfg_data;
  logic                     s_axis_cfg_last;
  logic                     s_axis_cfg_valid;
  logic                     s_axis_cfg_ready;
  logic [FRAME_W-1:0]       s_axis_dat_data;
  logic                     s_axis_dat_valid;
  logic                     s_axis_dat_ready;
  logic [FRAME_W-1:0]       m_axis_frame_data;
  logic                     m_axis_frame_valid;
  logic                     m_axis_frame_last;
  logic                     m_axis_frame_ready;
  logic                     frame_err;

  modport slave (
    input  s_axis_req_cfg_len, s_axis_req_num_pkts, s_axis_req_valid,
    input  s_axis_cfg_data, s_axis_cfg_last, s_axis_cfg_valid,
    input  s_axis_dat_data, s_axis_dat_valid, m_axis_frame_ready,
    output s_axis_req_ready, s_axis_cfg_ready, s_axis_dat_ready,
    output m_axis_frame_data, m_axis_frame_valid, m_axis_frame_last, frame_err
  );

  modport master (
    output s_axis_req_cfg_len, s_axis_req_num_pkts, s_axis_req_valid,
    output s_axis_cfg_data, s_axis_cfg_last, s_axis_cfg_valid,
    output s_axis_dat_data, s_axis_dat_valid, m_axis_frame_ready,
    input  s_axis_req_ready, s_axis_cfg_ready, s_axis_dat_ready,
    input  m_axis_frame_data, m_axis_frame_valid, m_axis_frame_last, frame_err
  );
endinterface

// File: rtl/pdcch_frame_builder_axis_out_slice.sv
// rtl/pdcch_frame_builder_axis_out_slice.sv - one-entry registered output stage holding data/last under backpressure
module axis_out_slice #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         free,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready
);
  assign free = !m_valid || m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (free) begin
      m_valid <= load;
      if (load) begin
        m_data <= in_data;
        m_last <= in_last;
      end
    end
  end
endmodule

// File: rtl/pdcch_frame_builder.sv
// rtl/pdcch_frame_builder.sv - merges a frame request, config stream and data stream into one header-led frame
module pdcch_frame_builder
  import pdcch_frame_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_CFG_WORDS = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pdcch_frame_builder_if.slave bus
);
  state_t                   state;
  logic [HDR_CFG_LEN_W-1:0] cfg_len_q;
  logic [HDR_CFG_LEN_W-1:0] cfg_cnt;
  logic [HDR_NPKT_W-1:0]    pkt_cnt;
  logic                     req_ready_q;
  logic                     frame_err_q;
  logic                     out_free;
  logic                     out_load;
  logic                     out_last;
  logic [DATA_WIDTH-1:0]    out_data;

  wire req_hs    = bus.s_axis_req_valid && req_ready_q;
  wire req_bad   = (bus.s_axis_req_cfg_len > HDR_CFG_LEN_W'(MAX_CFG_WORDS)) ||
                   (bus.s_axis_req_num_pkts == '0);
  wire cfg_ready = (state == CFG) && out_free;
  wire dat_ready = (state == DAT) && out_free;
  wire cfg_hs    = cfg_ready && bus.s_axis_cfg_valid;
  wire dat_hs    = dat_ready && bus.s_axis_dat_valid;
  wire hdr_load  = (state == HDR) && out_free;
  wire cfg_final = (cfg_cnt == cfg_len_q - HDR_CFG_LEN_W'(1));
  wire dat_final = (pkt_cnt == HDR_NPKT_W'(1));

  assign bus.s_axis_req_ready = req_ready_q;
  assign bus.s_axis_cfg_ready = cfg_ready;
  assign bus.s_axis_dat_ready = dat_ready;
  assign bus.frame_err        = frame_err_q;

  always_comb begin
    out_load = hdr_load || cfg_hs || dat_hs;
    out_last = dat_hs && dat_final;
    out_data = DATA_WIDTH'(hdr_pack(pkt_cnt, cfg_len_q));
    if (cfg_hs)      out_data = DATA_WIDTH'(bus.s_axis_cfg_data);
    else if (dat_hs) out_data = DATA_WIDTH'(bus.s_axis_dat_data);
  end

  // req_ready is registered so it is low during reset and rises with the first IDLE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cfg_len_q   <= '0;
      cfg_cnt     <= '0;
      pkt_cnt     <= '0;
      req_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_hs) begin
            if (req_bad) begin
              frame_err_q <= 1'b1;
            end else begin
              cfg_len_q   <= bus.s_axis_req_cfg_len;
              pkt_cnt     <= bus.s_axis_req_num_pkts;
              req_ready_q <= 1'b0;
              state       <= HDR;
            end
          end
        end
        HDR: begin
          if (hdr_load) begin
            cfg_cnt <= '0;
            state   <= (cfg_len_q != '0) ? CFG : DAT;
          end
        end
        CFG: begin
          if (cfg_hs) begin
            cfg_cnt <= cfg_cnt + HDR_CFG_LEN_W'(1);
            if (bus.s_axis_cfg_last != cfg_final) frame_err_q <= 1'b1;
            if (cfg_final) state <= DAT;
          end
        end
        DAT: begin
          if (dat_hs) begin
            pkt_cnt <= pkt_cnt - HDR_NPKT_W'(1);
            if (dat_final) begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_slice #(.W(DATA_WIDTH)) u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (out_load),
    .in_data (out_data),
    .in_last (out_last),
    .free    (out_free),
    .m_data  (bus.m_axis_frame_data),
    .m_last  (bus.m_axis_frame_last),
    .m_valid (bus.m_axis_frame_valid),
    .m_ready (bus.m_axis_frame_ready)
  );
endmodule

// File: tb/tb_pdcch_frame_builder.sv
// tb/tb_pdcch_frame_builder.sv - directed self-checking bench for pdcch_frame_builder
module tb_pdcch_frame_builder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pdcch_frame_builder_if bus();

  pdcch_frame_builder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;
  logic cfg_rdy_seen = 1'b0;
  logic [64:0] beats[$];
  int stamps[$];
  logic [64:0] exp_q[$];

  // downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = held low
  initial begin
    bus.m_axis_frame_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       bus.m_axis_frame_ready = ~bus.m_axis_frame_ready;
        2:       bus.m_axis_frame_ready = 1'b0;
        default: bus.m_axis_frame_ready = 1'b1;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (prev_stall && ({bus.m_axis_frame_last, bus.m_axis_frame_data} !== prev_beat))
        stall_viol++;
      prev_stall = bus.m_axis_frame_valid && !bus.m_axis_frame_ready;
      prev_beat  = {bus.m_axis_frame_last, bus.m_axis_frame_data};
      if (bus.m_axis_frame_valid && bus.m_axis_frame_ready) begin
        beats.push_back({bus.m_axis_frame_last, bus.m_axis_frame_data});
        stamps.push_back(cyc);
      end
      if (bus.s_axis_cfg_ready) cfg_rdy_seen = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send_req(input logic [9:0] cl, input logic [53:0] np);
    @(negedge clk);
    bus.s_axis_req_cfg_len  = cl;
    bus.s_axis_req_num_pkts = np;
    bus.s_axis_req_valid    = 1'b1;
    #1;
    for (int i = 0; i < 100 && !bus.s_axis_req_ready; i++) begin
      @(negedge clk); #1;
    end
    chk("req_ready_wait", {64'd0, bus.s_axis_req_ready}, 65'd1);
    @(posedge clk); #1;
    bus.s_axis_req_valid = 1'b0;
  endtask

  task automatic send_beat(input bit is_cfg, input logic [63:0] d, input logic last);
    @(negedge clk);
    if (is_cfg) begin
      bus.s_axis_cfg_data = d; bus.s_axis_cfg_last = last; bus.s_axis_cfg_valid = 1'b1;
    end else begin
      bus.s_axis_dat_data = d; bus.s_axis_dat_valid = 1'b1;
    end
    #1;
    for (int i = 0; i < 100 && !(is_cfg ? bus.s_axis_cfg_ready : bus.s_axis_dat_ready); i++) begin
      @(negedge clk); #1;
    end
    chk(is_cfg ? "cfg_ready_wait" : "dat_ready_wait",
        {64'd0, (is_cfg ? bus.s_axis_cfg_ready : bus.s_axis_dat_ready)}, 65'd1);
    @(posedge clk); #1;
    bus.s_axis_cfg_valid = 1'b0;
    bus.s_axis_dat_valid = 1'b0;
  endtask

  function automatic logic [63:0] cfg_word(input int tag, input int i);
    return 64'hC000_0000_0000_0000 | 64'(tag << 8) | 64'(i);
  endfunction

  function automatic logic [63:0] dat_word(input int tag, input int i);
    return 64'hD000_0000_0000_0000 | 64'(tag << 8) | 64'(i);
  endfunction

  // drives one full frame; bad_idx marks a config word whose last flag is forced high
  task automatic run_frame(input int cl, input int np, input int tag, input int bad_idx,
                           input logic [63:0] hdr);
    beats.delete(); stamps.delete(); exp_q.delete();
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < cl; i++) exp_q.push_back({1'b0, cfg_word(tag, i)});
    for (int i = 0; i < np; i++) exp_q.push_back({(i == np - 1), dat_word(tag, i)});
    send_req(10'(cl), 54'(np));
    for (int i = 0; i < cl; i++) send_beat(1'b1, cfg_word(tag, i), (i == cl - 1) || (i == bad_idx));
    for (int i = 0; i < np; i++) send_beat(1'b0, dat_word(tag, i), 1'b0);
    for (int i = 0; i < 100 && beats.size() < exp_q.size(); i++) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 65'(beats.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) chk(tag, beats[i], exp_q[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.s_axis_req_cfg_len = '0; bus.s_axis_req_num_pkts = '0; bus.s_axis_req_valid = 1'b0;
    bus.s_axis_cfg_data = '0; bus.s_axis_cfg_last = 1'b0; bus.s_axis_cfg_valid = 1'b0;
    bus.s_axis_dat_data = '0; bus.s_axis_dat_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {64'd0, bus.s_axis_req_ready}, 65'd0);
    chk("rst_cfg_ready", {64'd0, bus.s_axis_cfg_ready}, 65'd0);
    chk("rst_dat_ready", {64'd0, bus.s_axis_dat_ready}, 65'd0);
    chk("rst_m_valid",   {64'd0, bus.m_axis_frame_valid}, 65'd0);
    chk("rst_m_data",    {1'b0, bus.m_axis_frame_data}, 65'd0);
    chk("rst_frame_err", {64'd0, bus.frame_err}, 65'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) full-throughput frame
    run_frame(3, 2, 1, -1, 64'h0000_0000_0000_0803);
    check_beats("t1_beat");
    if (stamps.size() == 6) chk("t1_no_gaps", 65'(stamps[5] - stamps[0]), 65'd5);
    chk("t1_frame_err", {64'd0, bus.frame_err}, 65'd0);

    // 2) toggling downstream ready
    rdy_mode = 1; stall_viol = 0;
    run_frame(3, 2, 2, -1, 64'h0000_0000_0000_0803);
    check_beats("t2_beat");
    chk("t2_stable", 65'(stall_viol), 65'd0);
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // 3) no config words
    cfg_rdy_seen = 1'b0;
    run_frame(0, 1, 3, -1, 64'h0000_0000_0000_0400);
    check_beats("t3_beat");
    chk("t3_no_cfg_ready", {64'd0, cfg_rdy_seen}, 65'd0);

    // 4) oversized cfg_len rejected, next frame still built
    beats.delete();
    send_req(10'd16, 54'd5);
    repeat (5) @(negedge clk);
    #1;
    chk("t4_frame_err", {64'd0, bus.frame_err}, 65'd1);
    chk("t4_no_beats", 65'(beats.size()), 65'd0);
    chk("t4_req_ready", {64'd0, bus.s_axis_req_ready}, 65'd1);
    run_frame(1, 1, 4, -1, 64'h0000_0000_0000_0401);
    check_beats("t4_beat");

    pulse_reset();
    chk("rst2_frame_err", {64'd0, bus.frame_err}, 65'd0);

    // 5) cfg_last asserted early
    run_frame(2, 1, 5, 0, 64'h0000_0000_0000_0402);
    check_beats("t5_beat");
    chk("t5_frame_err", {64'd0, bus.frame_err}, 65'd1);

    // 6) reset while in CFG with a beat held in the output register
    beats.delete();
    send_req(10'd3, 54'd1);
    send_beat(1'b1, cfg_word(6, 0), 1'b0);
    rdy_mode = 2;
    @(negedge clk); #1;
    chk("t6_pre_valid", {64'd0, bus.m_axis_frame_valid}, 65'd1);
    #1; reset_n = 1'b0; #1;
    chk("t6_m_valid", {64'd0, bus.m_axis_frame_valid}, 65'd0);
    chk("t6_m_data", {1'b0, bus.m_axis_frame_data}, 65'd0);
    chk("t6_cfg_ready", {64'd0, bus.s_axis_cfg_ready}, 65'd0);
    chk("t6_req_ready", {64'd0, bus.s_axis_req_ready}, 65'd0);
    chk("t6_frame_err", {64'd0, bus.frame_err}, 65'd0);
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1, 1, 7, -1, 64'h0000_0000_0000_0401);
    check_beats("t6_beat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
